// File: rtl/shift_rotate_seq_pkg.sv
// Shared definitions for the shift/rotate sequencer: opcode values,
// sequencer states and default widths.
package shift_rotate_seq_pkg;

  localparam int SR_WIDTH = 16;
  localparam int SR_CNT_W = 8;

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_ROR = 3'b001;
  localparam logic [2:0] OP_RCL = 3'b010;
  localparam logic [2:0] OP_RCR = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_SAL = 3'b110;
  localparam logic [2:0] OP_SAR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_rotate_seq_step.sv
// Combinational single-bit shift/rotate step through {CF, operand}.
// Byte mode touches only bits 7:0; the upper bits pass through unchanged.
module shift_rotate_seq_step
  import shift_rotate_seq_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH
) (
  input  logic [2:0]       op_i,
  input  logic             w_i,
  input  logic             cf_i,
  input  logic [WIDTH-1:0] operand_i,
  output logic [WIDTH-1:0] operand_o,
  output logic             cf_o,
  output logic             of_o
);

  logic [WIDTH-1:0] word_res;
  logic             word_cf;
  logic [7:0]       byte_res;
  logic             byte_cf;
  logic [7:0]       b;
  logic             res_top;
  logic             res_top2;
  logic             old_top;

  assign b = operand_i[7:0];

  // One step on the full word.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case can leave it unassigned and infer a latch.
    word_res = operand_i;
    word_cf  = cf_i;
    case (op_i)
      OP_ROL: begin
        word_res = {operand_i[WIDTH-2:0], operand_i[WIDTH-1]};
        word_cf  = operand_i[WIDTH-1];
      end
      OP_ROR: begin
        word_res = {operand_i[0], operand_i[WIDTH-1:1]};
        word_cf  = operand_i[0];
      end
      OP_RCL: begin
        word_res = {operand_i[WIDTH-2:0], cf_i};
        word_cf  = operand_i[WIDTH-1];
      end
      OP_RCR: begin
        word_res = {cf_i, operand_i[WIDTH-1:1]};
        word_cf  = operand_i[0];
      end
      OP_SHL, OP_SAL: begin
        word_res = {operand_i[WIDTH-2:0], 1'b0};
        word_cf  = operand_i[WIDTH-1];
      end
      OP_SHR: begin
        word_res = {1'b0, operand_i[WIDTH-1:1]};
        word_cf  = operand_i[0];
      end
      OP_SAR: begin
        word_res = {operand_i[WIDTH-1], operand_i[WIDTH-1:1]};
        word_cf  = operand_i[0];
      end
      default: begin
        word_res = operand_i;
        word_cf  = cf_i;
      end
    endcase
  end

  // One step on the low byte.
  always_comb begin
    byte_res = b;
    byte_cf  = cf_i;
    case (op_i)
      OP_ROL: begin
        byte_res = {b[6:0], b[7]};
        byte_cf  = b[7];
      end
      OP_ROR: begin
        byte_res = {b[0], b[7:1]};
        byte_cf  = b[0];
      end
      OP_RCL: begin
        byte_res = {b[6:0], cf_i};
        byte_cf  = b[7];
      end
      OP_RCR: begin
        byte_res = {cf_i, b[7:1]};
        byte_cf  = b[0];
      end
      OP_SHL, OP_SAL: begin
        byte_res = {b[6:0], 1'b0};
        byte_cf  = b[7];
      end
      OP_SHR: begin
        byte_res = {1'b0, b[7:1]};
        byte_cf  = b[0];
      end
      OP_SAR: begin
        byte_res = {b[7], b[7:1]};
        byte_cf  = b[0];
      end
      default: begin
        byte_res = b;
        byte_cf  = cf_i;
      end
    endcase
  end

  // Select width and derive the overflow flag of this step.
  always_comb begin
    if (w_i) begin
      operand_o = word_res;
      cf_o      = word_cf;
      res_top   = word_res[WIDTH-1];
      res_top2  = word_res[WIDTH-2];
      old_top   = operand_i[WIDTH-1];
    end else begin
      operand_o = {operand_i[WIDTH-1:8], byte_res};
      cf_o      = byte_cf;
      res_top   = byte_res[7];
      res_top2  = byte_res[6];
      old_top   = b[7];
    end
    case (op_i)
      OP_ROR, OP_RCR: of_o = res_top ^ res_top2;
      OP_SHR:         of_o = old_top;
      OP_SAR:         of_o = 1'b0;
      default:        of_o = res_top ^ cf_o;
    endcase
  end

endmodule

// File: rtl/shift_rotate_seq.sv
// Multi-cycle 8088 shift/rotate sequencer: one bit per clock through
// {CF, operand} for the full, unmasked count, with START/BUSY/DONE handshake.
module shift_rotate_seq
  import shift_rotate_seq_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH,
  parameter int CNT_W = SR_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic             w_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] r_o,
  output logic             cf_o,
  output logic             of_o
);

  state_e           state_q;
  logic [2:0]       op_q;
  logic             w_q;
  logic [WIDTH-1:0] opnd_q;
  logic             cf_q;
  logic             of_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] opnd_d;
  logic             cf_d;
  logic             of_d;

  shift_rotate_seq_step #(.WIDTH(WIDTH)) u_step (
    .op_i      (op_q),
    .w_i       (w_q),
    .cf_i      (cf_q),
    .operand_i (opnd_q),
    .operand_o (opnd_d),
    .cf_o      (cf_d),
    .of_o      (of_d)
  );

  // Sequencer FSM: accept a request, step once per clock, pulse DONE.
  // NOTE: asynchronous active-low reset clears state and every visible
  // output immediately, discarding any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ROL;
      w_q     <= 1'b0;
      opnd_q  <= '0;
      cf_q    <= 1'b0;
      of_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            op_q   <= op_i;
            w_q    <= w_i;
            opnd_q <= a_i;
            cf_q   <= cin_i;
            cnt_q  <= cnt_i;
            busy_q <= 1'b1;
            if (cnt_i == '0) begin
              // Zero count: result is the operand, OF keeps its old value.
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          opnd_q <= opnd_d;
          cf_q   <= cf_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            of_q    <= of_d;
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign r_o    = opnd_q;
  assign cf_o   = cf_q;
  assign of_o   = of_q;

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Self-checking bench for shift_rotate_seq: directed cases plus random
// operations compared with a closed-form model of the shift/rotate rules.
module tb_shift_rotate_seq;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  op_i;
  logic        w_i;
  logic [15:0] a_i;
  logic [7:0]  cnt_i;
  logic        cin_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] r_o;
  logic        cf_o;
  logic        of_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_of = 1'b0;   // OF as the model last left it

  shift_rotate_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .op_i    (op_i),
    .w_i     (w_i),
    .a_i     (a_i),
    .cnt_i   (cnt_i),
    .cin_i   (cin_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .r_o     (r_o),
    .cf_o    (cf_o),
    .of_o    (of_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Closed-form result of the whole operation (not stepwise).
  function automatic void model(input logic [2:0] op, input logic w, input logic [15:0] a,
                                input logic [7:0] cnt, input logic cin, input logic prev_of,
                                output logic [15:0] r, output logic cf, output logic of);
    int          n;
    int          c;
    int          k;
    int          s;
    logic [31:0] mask;
    logic [31:0] m1;
    logic [31:0] v;
    logic [31:0] x;
    logic [31:0] ext;
    logic [31:0] res;
    logic        sign;
    n    = w ? 16 : 8;
    c    = int'(cnt);
    mask = (32'd1 << n) - 1;
    m1   = (32'd1 << (n + 1)) - 1;
    v    = {16'd0, a} & mask;
    sign = v[n-1];
    res  = v;
    cf   = cin;
    of   = prev_of;
    if (c != 0) begin
      case (op)
        3'd0: begin
          k = c % n;
          res = ((v << k) | (v >> (n - k))) & mask;
          cf = res[0];
          of = res[n-1] ^ cf;
        end
        3'd1: begin
          k = c % n;
          res = ((v >> k) | (v << (n - k))) & mask;
          cf = res[n-1];
          of = res[n-1] ^ res[n-2];
        end
        3'd2: begin
          k = c % (n + 1);
          x = v | ({31'd0, cin} << n);
          x = ((x << k) | (x >> (n + 1 - k))) & m1;
          res = x & mask;
          cf = x[n];
          of = res[n-1] ^ cf;
        end
        3'd3: begin
          k = c % (n + 1);
          x = v | ({31'd0, cin} << n);
          x = ((x >> k) | (x << (n + 1 - k))) & m1;
          res = x & mask;
          cf = x[n];
          of = res[n-1] ^ res[n-2];
        end
        3'd4, 3'd6: begin
          res = (c >= n) ? 32'd0 : ((v << c) & mask);
          cf = (c <= n) ? v[n-c] : 1'b0;
          of = res[n-1] ^ cf;
        end
        3'd5: begin
          res = (c >= n) ? 32'd0 : (v >> c);
          cf = (c <= n) ? v[c-1] : 1'b0;
          of = (c == 1) ? v[n-1] : 1'b0;
        end
        default: begin
          s = (c >= n) ? n : c;
          ext = sign ? (v | ~mask) : v;
          res = 32'($signed(ext) >>> s) & mask;
          cf = (c <= n) ? v[c-1] : sign;
          of = 1'b0;
        end
      endcase
    end
    r = w ? res[15:0] : {a[15:8], res[7:0]};
    if (c == 0) r = a;
  endfunction

  // Issue one operation, optionally pulse START again in cycle 'glitch'
  // of the run, then check latency, BUSY span, results and hold behaviour.
  task automatic run_op(input string tag, input logic [2:0] op, input logic w,
                        input logic [15:0] a, input logic [7:0] cnt, input logic cin,
                        input int glitch);
    logic [15:0] er;
    logic        ecf;
    logic        eof;
    int          cyc;
    int          busy_cyc;
    bit          seen;
    model(op, w, a, cnt, cin, exp_of, er, ecf, eof);
    exp_of = eof;
    @(negedge clk);
    op_i = op; w_i = w; a_i = a; cnt_i = cnt; cin_i = cin; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    op_i = 3'($urandom); a_i = 16'($urandom); cin_i = 1'($urandom);
    cyc = 0; busy_cyc = 0; seen = 0;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (busy_o) busy_cyc++;
      if (done_o) seen = 1;
      else if (cyc == glitch) begin
        start_i = 1'b1; cnt_i = 8'd0; a_i = 16'($urandom);
      end else start_i = 1'b0;
    end
    start_i = 1'b0;
    check({tag, "_timeout"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cyc), int'(cnt) + 1);
    check({tag, "_busy"}, 32'(busy_cyc), int'(cnt) + 1);
    check({tag, "_r"}, 32'(r_o), 32'(er));
    check({tag, "_cf"}, 32'(cf_o), 32'(ecf));
    check({tag, "_of"}, 32'(of_o), 32'(eof));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
    check({tag, "_hold"}, 32'({r_o, cf_o, of_o}), 32'({er, ecf, eof}));
  endtask

  initial begin
    logic [7:0] rc;
    rst_n = 1'b0; start_i = 1'b0; op_i = 3'd0; w_i = 1'b0;
    a_i = 16'd0; cnt_i = 8'd0; cin_i = 1'b0;
    #3;
    check("reset_state", 32'({busy_o, done_o, r_o, cf_o, of_o}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_op("rcl_w_1", 3'd2, 1'b1, 16'h8001, 8'd1, 1'b0, 0);
    check("rcl_w_1_lit", 32'({r_o, cf_o, of_o}), 32'({16'h0002, 1'b1, 1'b1}));
    run_op("rcr_w_1", 3'd3, 1'b1, 16'h0001, 8'd1, 1'b1, 0);
    check("rcr_w_1_lit", 32'({r_o, cf_o, of_o}), 32'({16'h8000, 1'b1, 1'b1}));
    run_op("rcl_w_17", 3'd2, 1'b1, 16'h1234, 8'd17, 1'b1, 0);
    check("rcl_w_17_lit", 32'({r_o, cf_o}), 32'({16'h1234, 1'b1}));
    run_op("sar_b_3", 3'd7, 1'b0, 16'hAB80, 8'd3, 1'b1, 0);
    check("sar_b_3_lit", 32'({r_o, cf_o, of_o}), 32'({16'hABF0, 1'b0, 1'b0}));
    run_op("shl_w_20", 3'd4, 1'b1, 16'hFFFF, 8'd20, 1'b1, 0);
    check("shl_w_20_lit", 32'({r_o, cf_o}), 32'({16'h0000, 1'b0}));
    run_op("cnt0", 3'd0, 1'b1, 16'hC3A5, 8'd0, 1'b1, 0);
    check("cnt0_lit", 32'({r_o, cf_o}), 32'({16'hC3A5, 1'b1}));
    run_op("sar_w_255", 3'd7, 1'b1, 16'h8001, 8'd255, 1'b0, 0);
    run_op("shr_b_1", 3'd5, 1'b0, 16'h5A81, 8'd1, 1'b0, 0);
    run_op("glitch", 3'd1, 1'b1, 16'h0F0F, 8'd6, 1'b0, 3);

    // Reset in the middle of a 10-step ROL.
    @(negedge clk);
    op_i = 3'd0; w_i = 1'b1; a_i = 16'h1357; cnt_i = 8'd10; cin_i = 1'b1; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", 32'(busy_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset", 32'({busy_o, done_o, r_o, cf_o, of_o}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_of = 1'b0;
    run_op("after_reset", 3'd0, 1'b1, 16'h1357, 8'd10, 1'b1, 0);

    // Random operations.
    for (int i = 0; i < 40; i++) begin
      rc = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
      run_op($sformatf("rnd%0d", i), 3'($urandom), 1'($urandom), 16'($urandom), rc,
             1'($urandom), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
